// File: rtl/vram_arbiter.sv
// Arbiter sharing one single-port VRAM between display reads, which always win, and writes.
// Define VRAM_WR_FIFO_EN to buffer writes in a FIFO_DEPTH-entry FIFO drained in free cycles.
module vram_arbiter #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 20,
  parameter int unsigned STARVE_LIM = 64,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              wr_req_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_ack_o,
  output logic              wr_busy_o,
  output logic              wr_starve_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int unsigned CntW = $clog2(STARVE_LIM + 1);
  localparam logic [CntW-1:0] LimCnt = CntW'(STARVE_LIM);

  typedef enum logic [1:0] {StIdle, StRd, StWr} state_e;

  state_e            state_q, state_d;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              wr_ack_q;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              wr_elig;
  logic              wr_grant;
  logic              ack_d;
  logic [ADDR_W-1:0] src_addr;
  logic [DATA_W-1:0] src_data;

`ifdef VRAM_WR_FIFO_EN
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wptr_q, rptr_q;
  logic [PtrW:0]     count_q;
  logic              push, full, empty;

  assign full      = (count_q == (PtrW + 1)'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign push      = wr_req_i && !wr_ack_q && !full;
  assign wr_elig   = !empty;
  assign src_addr  = fifo_addr_q[rptr_q];
  assign src_data  = fifo_data_q[rptr_q];
  assign ack_d     = push;
  assign wr_busy_o = !rst_i && (!empty || (wr_req_i && !wr_ack_q));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        fifo_addr_q[wptr_q] <= wr_addr_i;
        fifo_data_q[wptr_q] <= wr_data_i;
        wptr_q              <= wptr_q + 1'b1;
      end
      if (wr_grant) rptr_q <= rptr_q + 1'b1;
      case ({push, wr_grant})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
`else
  logic unused_fifo_depth;

  assign unused_fifo_depth = ^FIFO_DEPTH;
  assign wr_elig   = wr_req_i && !wr_ack_q;
  assign src_addr  = wr_addr_i;
  assign src_data  = wr_data_i;
  assign ack_d     = wr_grant;
  assign wr_busy_o = !rst_i && wr_req_i && !wr_ack_q;
`endif

  // Reads always win; the bus holds its last address/data when nothing is granted.
  always_comb begin
    state_d     = StIdle;
    wr_grant    = 1'b0;
    mem_addr_o  = addr_q;
    mem_we_o    = 1'b0;
    mem_wdata_o = wdata_q;
    cnt_d       = cnt_q;
    if (rst_i) begin
      mem_addr_o  = '0;
      mem_wdata_o = '0;
    end else if (rd_req_i) begin
      state_d    = StRd;
      mem_addr_o = rd_addr_i;
    end else if (wr_elig) begin
      state_d     = StWr;
      wr_grant    = 1'b1;
      mem_addr_o  = src_addr;
      mem_we_o    = 1'b1;
      mem_wdata_o = src_data;
    end
    if (wr_grant) begin
      cnt_d = '0;
    end else if (!rst_i && wr_elig && (cnt_q != LimCnt)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      wr_ack_q   <= 1'b0;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      // RAM data for a read issued last cycle is valid now; it reaches rd_data_o next cycle.
      rd_valid_q <= (state_q == StRd);
      if (state_q == StRd) rd_data_q <= mem_rdata_i;
      wr_ack_q   <= ack_d;
      cnt_q      <= cnt_d;
      addr_q     <= mem_addr_o;
      wdata_q    <= mem_wdata_o;
    end
  end

  assign rd_valid_o  = rd_valid_q;
  assign rd_data_o   = rd_data_q;
  assign wr_ack_o    = wr_ack_q;
  assign wr_starve_o = (cnt_q == LimCnt);

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: RAM model plus read/write scoreboards.
// Build with VRAM_WR_FIFO_EN defined to exercise the write-FIFO variant.
module tb_vram_arbiter;

  localparam int unsigned AW  = 10;
  localparam int unsigned DW  = 20;
  localparam int unsigned LIM = 8;

`ifdef VRAM_WR_FIFO_EN
  localparam int AckCyc    = 1;
  localparam int StarveOff = 1;
`else
  localparam int AckCyc    = 11;
  localparam int StarveOff = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic          wr_busy;
  logic          wr_starve;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int checks = 0;
  int fails  = 0;

  logic [DW-1:0]    ram    [1 << AW];
  logic [DW-1:0]    shadow [1 << AW];
  logic [DW-1:0]    rd_q   [$];
  logic [AW+DW-1:0] wr_q   [$];

  always #5 clk = ~clk;

  vram_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .STARVE_LIM(LIM),
    .FIFO_DEPTH(4)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .rd_req_i   (rd_req),
    .rd_addr_i  (rd_addr),
    .rd_valid_o (rd_valid),
    .rd_data_o  (rd_data),
    .wr_req_i   (wr_req),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .wr_ack_o   (wr_ack),
    .wr_busy_o  (wr_busy),
    .wr_starve_o(wr_starve),
    .mem_addr_o (mem_addr),
    .mem_we_o   (mem_we),
    .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  // Single-port synchronous VRAM
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Scoreboards: every rd_valid and every VRAM write must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_valid) begin
        checks++;
        if (rd_q.size() == 0) begin
          fails++;
          $display("FAIL rd_unexpected: got rd_valid data %h, expected no read", rd_data);
        end else begin
          logic [DW-1:0] exp_d;
          exp_d = rd_q.pop_front();
          if (rd_data !== exp_d) begin
            fails++;
            $display("FAIL rd_data: got %h, expected %h", rd_data, exp_d);
          end
        end
      end
      if (mem_we) begin
        checks++;
        if (wr_q.size() == 0) begin
          fails++;
          $display("FAIL wr_unexpected: got write %h<=%h, expected none", mem_addr, mem_wdata);
        end else begin
          logic [AW+DW-1:0] exp_w;
          exp_w = wr_q.pop_front();
          if ({mem_addr, mem_wdata} !== exp_w) begin
            fails++;
            $display("FAIL wr_order: got %h, expected %h", {mem_addr, mem_wdata}, exp_w);
          end
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_read(input int a);
    rd_req  = 1'b1;
    rd_addr = AW'(a);
    rd_q.push_back(shadow[a]);
  endtask

  task automatic present_write(input int a, input logic [DW-1:0] d);
    wr_req  = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    wr_q.push_back({AW'(a), d});
    shadow[a] = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rd_req  = 1'($urandom);
      rd_addr = AW'($urandom);
      wr_req  = 1'($urandom);
      wr_addr = AW'($urandom);
      wr_data = DW'($urandom);
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b0) begin
        fails++;
        $display("FAIL reset_we: got %b, expected 0", mem_we);
      end
      if (i == 1) begin
        checks++;
        if ({rd_valid, rd_data, wr_ack, wr_busy, wr_starve, mem_addr, mem_wdata} !== '0) begin
          fails++;
          $display("FAIL reset_outputs: got %b%h%b%b%b %h %h, expected all zero",
                   rd_valid, rd_data, wr_ack, wr_busy, wr_starve, mem_addr, mem_wdata);
        end
      end
      next_cycle();
    end
    rst    = 1'b0;
    rd_req = 1'b0;
    wr_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({rd_valid, rd_data, wr_ack, wr_busy, wr_starve, mem_we, mem_addr, mem_wdata} !== '0) begin
      fails++;
      $display("FAIL idle_after_reset: outputs not all zero (addr %h we %b)", mem_addr, mem_we);
    end
    next_cycle();
  endtask

  task automatic test_read_stream();
    for (int i = 0; i < 12; i++) begin
      if (i < 10) drive_read(i);
      else rd_req = 1'b0;
      @(negedge clk);
      checks++;
      if (rd_valid !== (i >= 2)) begin
        fails++;
        $display("FAIL stream_valid: cycle %0d got %b, expected %b", i, rd_valid, i >= 2);
      end
      next_cycle();
    end
    checks++;
    if (rd_q.size() != 0) begin
      fails++;
      $display("FAIL stream_drain: %0d reads outstanding, expected 0", rd_q.size());
    end
  endtask

  task automatic test_contention();
    present_write(5, 20'hABCDE);
    for (int i = 0; i < 14; i++) begin
      if (wr_req && wr_ack) wr_req = 1'b0;
      if (i < 10) drive_read(20 + i);
      else if (i == 11) drive_read(5);
      else rd_req = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_we !== (i == 10)) begin
        fails++;
        $display("FAIL contention_we: cycle %0d got %b, expected %b", i, mem_we, i == 10);
      end
      checks++;
      if (wr_ack !== (i == AckCyc)) begin
        fails++;
        $display("FAIL contention_ack: cycle %0d got %b, expected %b", i, wr_ack, i == AckCyc);
      end
      if (i == 5 || i == 12) begin
        checks++;
        if (wr_busy !== (i == 5)) begin
          fails++;
          $display("FAIL contention_busy: cycle %0d got %b, expected %b", i, wr_busy, i == 5);
        end
      end
      next_cycle();
    end
    checks++;
    if (rd_q.size() != 0 || wr_q.size() != 0) begin
      fails++;
      $display("FAIL contention_drain: rd %0d wr %0d outstanding, expected 0 0",
               rd_q.size(), wr_q.size());
    end
  endtask

  task automatic test_starve();
    present_write(7, 20'h12345);
    for (int i = 0; i < 16; i++) begin
      if (wr_req && wr_ack) wr_req = 1'b0;
      if (i < 12) drive_read(30 + i);
      else if (i == 13) drive_read(7);
      else rd_req = 1'b0;
      @(negedge clk);
      checks++;
      if (wr_starve !== (i >= int'(LIM) + StarveOff && i <= 12)) begin
        fails++;
        $display("FAIL starve: cycle %0d got %b, expected %b", i, wr_starve,
                 i >= int'(LIM) + StarveOff && i <= 12);
      end
      checks++;
      if (mem_we !== (i == 12)) begin
        fails++;
        $display("FAIL starve_we: cycle %0d got %b, expected %b", i, mem_we, i == 12);
      end
      next_cycle();
    end
    wr_req = 1'b0;
    checks++;
    if (rd_q.size() != 0 || wr_q.size() != 0) begin
      fails++;
      $display("FAIL starve_drain: rd %0d wr %0d outstanding, expected 0 0",
               rd_q.size(), wr_q.size());
    end
  endtask

  task automatic test_reset_midop();
    rd_req  = 1'b1;
    rd_addr = AW'(3);
    next_cycle();
    rd_req = 1'b0;
    rst    = 1'b1;
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (rd_valid !== 1'b0 || wr_ack !== 1'b0) begin
        fails++;
        $display("FAIL midop_reset: got valid %b ack %b, expected 0 0", rd_valid, wr_ack);
      end
      next_cycle();
    end
  endtask

`ifdef VRAM_WR_FIFO_EN
  task automatic test_fifo();
    int k = 0;
    present_write(200, DW'(32'h1000));
    for (int i = 0; i < 30; i++) begin
      if (wr_req && wr_ack) begin
        k++;
        if (k < 5) present_write(200 + k, DW'(32'h1000 + k));
        else wr_req = 1'b0;
      end
      if (i < 12) drive_read(40 + i);
      else rd_req = 1'b0;
      @(negedge clk);
      if (i < 12) begin
        checks++;
        if (mem_we !== 1'b0) begin
          fails++;
          $display("FAIL fifo_read_prio: cycle %0d got we %b, expected 0", i, mem_we);
        end
      end
      if (i >= 8 && i < 12) begin
        checks++;
        if (wr_ack !== 1'b0 || wr_busy !== 1'b1) begin
          fails++;
          $display("FAIL fifo_full_hold: cycle %0d got ack %b busy %b, expected 0 1",
                   i, wr_ack, wr_busy);
        end
      end
      if (i == 14) begin
        checks++;
        if (wr_ack !== 1'b1) begin
          fails++;
          $display("FAIL fifo_fifth_ack: cycle 14 got %b, expected 1", wr_ack);
        end
      end
      next_cycle();
    end
    checks++;
    if (k != 5 || wr_q.size() != 0 || wr_busy !== 1'b0) begin
      fails++;
      $display("FAIL fifo_drain: acks %0d pending %0d busy %b, expected 5 0 0",
               k, wr_q.size(), wr_busy);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]    = DW'(i + 100);
      shadow[i] = DW'(i + 100);
    end
    rst     = 1'b1;
    rd_req  = 1'b0;
    rd_addr = '0;
    wr_req  = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    test_reset();
    test_read_stream();
    test_contention();
    test_starve();
    test_reset_midop();
`ifdef VRAM_WR_FIFO_EN
    test_fifo();
`endif
    next_cycle();
    checks++;
    if (rd_q.size() != 0 || wr_q.size() != 0) begin
      fails++;
      $display("FAIL final_drain: rd %0d wr %0d outstanding, expected 0 0",
               rd_q.size(), wr_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
